// File: rtl/telemetry_tx_if.sv
// Packet request, payload stream and serial status for the telemetry transmitter.
// The master side is the flight state machine; the slave side is telemetry_tx.
interface telemetry_tx_if;
  logic       pkt_start;
  logic [7:0] pkt_type;
  logic [4:0] pkt_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       TxD;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output pkt_start, pkt_type, pkt_len, pl_data, pl_valid,
    input  pl_ready, TxD, busy, done, err
  );

  modport slave (
    input  pkt_start, pkt_type, pkt_len, pl_data, pl_valid,
    output pl_ready, TxD, busy, done, err
  );
endinterface

// File: rtl/telemetry_tx.sv
// Framed 8N1 UART telemetry transmitter: AA 55 type len payload csum.
// The packet FSM picks the next byte; the serializer shifts it out at BIT_DIV clocks per bit.
module telemetry_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int MAX_LEN  = 16
) (
  input  logic           clk,
  input  logic           reset,
  telemetry_tx_if.slave  bus
);

  localparam int BIT_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W   = $clog2(BIT_DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [4:0]       MAX_LEN_V = 5'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, TYPE, LEN, PAYLOAD, CSUM} pkt_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  pkt_state_t       pst, pst_nxt;
  ser_state_t       sst;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;
  logic [7:0]       type_q, csum, hold;
  logic [4:0]       len_q, acc_cnt, ld_cnt;
  logic             hold_full, done_q, err_q;

  logic             bit_end, byte_end, accept, reject, hs;
  logic             ld, csum_en, pay_slot, pay_load, done_set;
  logic [7:0]       ld_byte, pay_byte;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign bit_end  = (baud_cnt == BIT_LAST);
  assign byte_end = (sst == S_STOP) && bit_end;
  assign accept   = (pst == IDLE) && bus.pkt_start && (bus.pkt_len <= MAX_LEN_V);
  assign reject   = (pst == IDLE) && bus.pkt_start && (bus.pkt_len > MAX_LEN_V);

  assign bus.busy     = (pst != IDLE);
  assign bus.pl_ready = bus.busy && (acc_cnt < len_q) && !hold_full;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign hs           = bus.pl_valid && bus.pl_ready;

  // Packet FSM: state register
  always_ff @(posedge clk) begin
    if (reset) pst <= IDLE;
    else       pst <= pst_nxt;
  end

  // Packet FSM: next state
  always_comb begin
    pst_nxt = pst;
    case (pst)
      IDLE:    if (accept)   pst_nxt = SYNC0;
      SYNC0:   if (byte_end) pst_nxt = SYNC1;
      SYNC1:   if (byte_end) pst_nxt = TYPE;
      TYPE:    if (byte_end) pst_nxt = LEN;
      LEN:     if (byte_end) pst_nxt = (len_q == 5'd0) ? CSUM : PAYLOAD;
      PAYLOAD: if (byte_end && ld_cnt == len_q) pst_nxt = CSUM;
      CSUM:    if (byte_end) pst_nxt = IDLE;
      default: pst_nxt = IDLE;
    endcase
  end

  // Packet FSM: byte selection; a waiting payload slot can load straight from pl_data
  always_comb begin
    ld       = 1'b0;
    ld_byte  = 8'h00;
    csum_en  = 1'b0;
    pay_slot = 1'b0;
    pay_load = 1'b0;
    pay_byte = hold_full ? hold : bus.pl_data;
    done_set = (pst == CSUM) && byte_end;
    case (pst)
      IDLE:    if (accept)   begin ld = 1'b1; ld_byte = 8'hAA; end
      SYNC0:   if (byte_end) begin ld = 1'b1; ld_byte = 8'h55; end
      SYNC1:   if (byte_end) begin ld = 1'b1; ld_byte = type_q; csum_en = 1'b1; end
      TYPE:    if (byte_end) begin ld = 1'b1; ld_byte = {3'b000, len_q}; csum_en = 1'b1; end
      LEN: begin
        if (byte_end && len_q == 5'd0) begin ld = 1'b1; ld_byte = csum; end
        else if (byte_end)             pay_slot = 1'b1;
      end
      PAYLOAD: begin
        if (byte_end && ld_cnt == len_q)        begin ld = 1'b1; ld_byte = csum; end
        else if (byte_end || sst == S_IDLE)     pay_slot = 1'b1;
      end
      default: ;
    endcase
    if (pay_slot && (hold_full || hs)) begin
      pay_load = 1'b1;
      ld       = 1'b1;
      ld_byte  = pay_byte;
      csum_en  = 1'b1;
    end
  end

  // Control: checksum, payload counters, holding flag, status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      csum      <= 8'h00;
      acc_cnt   <= 5'd0;
      ld_cnt    <= 5'd0;
      hold_full <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_set;
      err_q  <= reject;
      if (accept) begin
        csum      <= 8'h00;
        acc_cnt   <= 5'd0;
        ld_cnt    <= 5'd0;
        hold_full <= 1'b0;
      end else begin
        if (csum_en)  csum    <= csum_add(csum, ld_byte);
        if (hs)       acc_cnt <= acc_cnt + 5'd1;
        if (pay_load) ld_cnt  <= ld_cnt + 5'd1;
        if (pay_load && hold_full) hold_full <= 1'b0;
        else if (hs && !pay_load)  hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      type_q <= bus.pkt_type;
      len_q  <= bus.pkt_len;
    end
    if (hs && !pay_load) hold <= bus.pl_data;
  end

  // Serializer: start, 8 data bits LSB first, stop; baud counter restarts on every load
  always_ff @(posedge clk) begin
    if (reset) begin
      sst      <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
    end else if (ld) begin
      sst      <= S_START;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
    end else if (sst != S_IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        case (sst)
          S_START: sst <= S_DATA;
          S_DATA: begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) sst <= S_STOP;
          end
          default: sst <= S_IDLE;
        endcase
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld)                          shifter <= ld_byte;
    else if (sst == S_DATA && bit_end) shifter <= {1'b0, shifter[7:1]};
  end

  always_comb begin
    case (sst)
      S_START: bus.TxD = 1'b0;
      S_DATA:  bus.TxD = shifter[0];
      default: bus.TxD = 1'b1;
    endcase
  end

endmodule

// File: doc/telemetry_tx.md
# telemetry_tx

Framed UART telemetry transmitter: the outbound counterpart of the flight controller's `async_receiver` command link.
- The flight state machine hands it a packet type, a length and a stream of payload bytes (attitude, PID terms, motor commands).
- It emits a sync-framed, checksummed packet on `TxD` as 8N1 serial at the configured baud.
- It sits beside the receiver in `drone_top` and runs on the same 50 MHz clock.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, serial bit rate.
- `MAX_LEN`, 16, largest accepted payload length in bytes (≤ 31).
- Derived: `BIT_DIV = (CLK_FREQ + BAUD/2) / BAUD` clocks per bit (434 at defaults).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `pkt_start`  in  1  request to send a packet; sampled when `busy`=0.
- `pkt_type`  in  8  packet type byte; latched on acceptance.
- `pkt_len`  in  5  payload length in bytes; latched on acceptance.
- `pl_data`  in  8  payload byte.
- `pl_valid`  in  1  `pl_data` valid.
- `pl_ready`  out  1  block can take a payload byte. A transfer occurs on `pl_valid & pl_ready`.
- `TxD`  out  1  serial line; idles high.
- `busy`  out  1  packet in progress.
- `done`  out  1  one-cycle pulse when the checksum stop bit completes.
- `err`  out  1  one-cycle pulse when `pkt_start` is rejected.

## Operation
- Frame format, bytes in order: `0xAA`, `0x55`, `type`, `len`, `payload[0..len-1]`, `csum`.
- Checksum: `csum = (type + len + Σpayload) mod 256`, held in an 8-bit accumulator. Sync bytes are excluded.
- Each byte is sent as a start bit (0), 8 data bits LSB first, then a stop bit (1). Every bit lasts exactly `BIT_DIV` clocks.
- Packet FSM states: `IDLE`, `SYNC0`, `SYNC1`, `TYPE`, `LEN`, `PAYLOAD`, `CSUM`, then back to `IDLE`.
- `len`=0: go from `LEN` directly to `CSUM`.
- Byte serializer FSM states: `S_IDLE`, `S_START`, `S_DATA` (3-bit index), `S_STOP`. A baud counter runs from 0 to `BIT_DIV-1` and is reset at every byte load.
- Packet acceptance:
  - `pkt_start`=1 with `busy`=0 and `pkt_len` ≤ `MAX_LEN`: latch `type` and `len`, clear the checksum, set `busy`.
  - `pkt_len` > `MAX_LEN`: reject. Pulse `err`, `busy` stays 0, no `TxD` activity.
  - `pkt_start` while `busy`=1: ignored silently. No `err`.
- Payload path:
  - A one-byte holding register feeds the serializer.
  - `pl_ready` = `busy` & (payload bytes accepted < `len`) & holding register empty. The first byte can therefore be accepted while the header is still being sent.
  - At each byte boundary in `PAYLOAD`, the holding byte moves into the shifter and the checksum accumulates it.
  - If the holding register is empty at a boundary (underrun), `TxD` stays high. The start bit begins on the cycle after the byte is accepted. There is no timeout.
- End of packet: after the stop bit of `csum`, pulse `done`, clear `busy`, return to `IDLE`.

## Timing
- Reset values: `TxD`=1, `busy`=0, `pl_ready`=0, `done`=0, `err`=0. Both FSMs go to idle and all counters and the checksum clear.
- Start of packet: with `pkt_start` accepted at edge N, `busy`=1 and `TxD`=0 (start bit of `0xAA`) from cycle N+1.
- Header, checksum, and payload bytes that are already held all go out back to back: no idle gap between a stop bit and the next start bit.
- Packet duration with no underrun: `(5+len)·10·BIT_DIV` cycles from N+1 to the last stop-bit cycle.
- `done` is asserted in the cycle after the last stop-bit cycle, and `busy`=0 in that same cycle.
- A new `pkt_start` may be accepted in the same cycle that `done` is high.
- `err` is asserted in the cycle after the rejected `pkt_start` edge.
- Extra `pl_valid` beyond `len` bytes is never acknowledged, because `pl_ready` stays 0.
- Reset mid-packet: `TxD`=1 on the next cycle. The partial byte is truncated and no `done` is produced.
- `pkt_start` and `reset` asserted together: reset wins.

## Test plan
Use `CLK_FREQ`=1000 and `BAUD`=100, giving `BIT_DIV`=10.
- Basic packet: type=0x01, len=2, payload 0x10, 0x20 supplied with `pl_valid` held high. `TxD` decodes to AA 55 01 02 10 20 33. Packet lasts 700 cycles, `done` pulses once, `busy` falls in the same cycle as `done`.
- Zero length: type=0x7F, len=0. Frame is AA 55 7F 00 7F, lasting 500 cycles. `pl_ready` is never asserted.
- Checksum wrap: type=0xFF, len=1, payload 0x02. Checksum byte is 0x02.
- Underrun: len=2, second byte presented 150 cycles after the first byte's stop bit. `TxD` stays high through the gap, the start bit begins 1 cycle after the handshake, and the checksum is still correct.
- Rejects: `pkt_len`=17 pulses `err`, with `busy`=0 and `TxD` held at 1. `pkt_start` while busy changes nothing: no `err` and the in-flight frame is intact.
- Reset mid-byte: reset asserted during the data bits of `0x55`. `TxD`=1 and `busy`=0 the next cycle with no `done`. A following packet is sent correctly.
